// File: rtl/ysyx_23060136_elastic_seg_pkg.sv
// ysyx_23060136_PIPE_PKG: shared stage payload types, reset encodings and segment limits
package ysyx_23060136_PIPE_PKG;
  localparam int SEG_MAX_DEPTH = 8;
  localparam logic [31:0] PC_RST = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        commit;
    logic [63:0] rs1_data;
    logic [63:0] csr_rs_data;
    logic [63:0] imm;
    logic [3:0]  jump_ctl;
    logic [3:0]  cmp_ctl;
    logic [2:0]  wb_ctl;
    logic [4:0]  mem_ctl;
    logic        system_halt;
  } exu2_payload_t;
  localparam int EXU2_W = $bits(exu2_payload_t);
  localparam exu2_payload_t EXU2_RST = '{pc: PC_RST, inst: NOP_INST, default: '0};
endpackage

// File: rtl/ysyx_23060136_elastic_seg_stage.sv
// ysyx_23060136_seg_stage: one valid+payload register with load and clear
module ysyx_23060136_seg_stage
  import ysyx_23060136_PIPE_PKG::*;
#(
  parameter int W = 64,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  output logic         v,
  output logic [W-1:0] d
);
  logic v_q, v_d;
  logic [W-1:0] d_q, d_d;
  // clear wins over load; an invalid payload is always stored as RST
  always_comb begin
    v_d = clear ? 1'b0 : load ? v_in : v_q;
    d_d = clear ? RST : load ? (v_in ? d_in : RST) : d_q;
  end
  // stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= RST;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
  assign v = v_q;
  assign d = d_q;
endmodule

// File: rtl/ysyx_23060136_elastic_seg.sv
// ysyx_23060136_elastic_seg: elastic valid/ready pipeline segment with stall, deferred flush and occupancy
module ysyx_23060136_elastic_seg
  import ysyx_23060136_PIPE_PKG::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       flush_pend,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int OW = $clog2(DEPTH+1);
  logic v [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  logic adv [DEPTH];
  logic flush_pend_q, flush_pend_d, flush_eff, go;
  logic [OW-1:0] occ_q, occ_d;
  if (DEPTH < 1 || DEPTH > SEG_MAX_DEPTH) begin : g_bad_depth
    $error("ysyx_23060136_elastic_seg: DEPTH %0d outside 1..%0d", DEPTH, SEG_MAX_DEPTH);
  end
  assign flush_eff = (flush | flush_pend_q) & !stall;
  assign go = !stall & !flush_eff;
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    logic v_src;
    logic [DATA_W-1:0] d_src;
    if (i == DEPTH - 1) begin : g_last
      assign adv[i] = !v[i] | out_ready;
    end else begin : g_mid
      assign adv[i] = !v[i] | adv[i+1];
    end
    if (i == 0) begin : g_head
      assign v_src = in_valid;
      assign d_src = in_data;
    end else begin : g_body
      assign v_src = v[i-1];
      assign d_src = d[i-1];
    end
    ysyx_23060136_seg_stage #(.W(DATA_W), .RST(RST_DATA)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (go & adv[i]),
      .clear (flush_eff),
      .v_in  (v_src),
      .d_in  (d_src),
      .v     (v[i]),
      .d     (d[i])
    );
  end
  assign in_ready   = adv[0] & go;
  assign out_valid  = v[DEPTH-1];
  assign out_data   = d[DEPTH-1];
  assign flush_pend = flush_pend_q;
  assign occ        = occ_q;
  // a flush seen under stall is remembered until the stall drops; occ tracks accepted minus consumed
  always_comb begin
    flush_pend_d = stall & (flush_pend_q | flush);
    occ_d = flush_eff ? '0 : occ_q + OW'(in_valid & in_ready) - OW'(out_valid & out_ready & go);
  end
  // flush-pending and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
      occ_q <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060136_elastic_seg.sv
// tb_ysyx_23060136_elastic_seg: directed bench with FIFO scoreboard on a DEPTH=3 segment plus DEPTH=2/4 checks
module tb_ysyx_23060136_elastic_seg;
  localparam logic [7:0] RD = 8'hE0;
  logic clk = 1'b0, rst, in_valid, out_ready, stall, flush;
  logic [7:0] in_data;
  logic r3, ov3, fp3, r2, ov2, fp2, r4, ov4, fp4;
  logic [7:0] od3, od2, od4;
  logic [1:0] oc3, oc2;
  logic [2:0] oc4;
  int vec = 0, err = 0;
  logic [7:0] q[$];
  logic mfp = 1'b0;

  always #5 clk = ~clk;

  ysyx_23060136_elastic_seg #(.DATA_W(8), .DEPTH(3), .RST_DATA(RD)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r3), .in_data(in_data),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .stall(stall),
    .flush(flush), .flush_pend(fp3), .occ(oc3));
  ysyx_23060136_elastic_seg #(.DATA_W(8), .DEPTH(2), .RST_DATA(RD)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .stall(stall),
    .flush(flush), .flush_pend(fp2), .occ(oc2));
  ysyx_23060136_elastic_seg #(.DATA_W(8), .DEPTH(4), .RST_DATA(RD)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .stall(stall),
    .flush(flush), .flush_pend(fp4), .occ(oc4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: scoreboard the DEPTH=3 instance at negedge, then step past posedge
  task automatic tick;
    logic fe;
    logic [7:0] e;
    @(negedge clk);
    if (rst) begin
      q.delete();
      mfp = 1'b0;
    end else begin
      fe = (flush | mfp) & !stall;
      chk("occ3_sb", 32'(oc3), 32'(q.size()));
      chk("flush_pend3_sb", 32'(fp3), 32'(mfp));
      chk("in_ready3_sb", 32'(r3), 32'(!stall && !fe && (q.size() < 3 || out_ready)));
      if (stall) mfp = mfp | flush;
      else if (fe) begin
        q.delete();
        mfp = 1'b0;
      end else begin
        if (ov3 && out_ready) begin
          chk("out_q_nonempty", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_data3_sb", 32'(od3), 32'(e));
          end
        end
        if (in_valid && r3) q.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0; stall = 0; flush = 0;
    tick;
    rst = 0;
    #1;
    chk("rst_ov3", ov3, 0);
    chk("rst_od3", od3, RD);
    chk("rst_occ3", oc3, 0);
    chk("rst_ir3", r3, 1);
    chk("rst_fp3", fp3, 0);
    chk("rst_ov2", ov2, 0);
    chk("rst_od4", od4, RD);
    chk("rst_occ4", oc4, 0);
    // back-to-back stream, latency 3
    out_ready = 1; in_valid = 1; in_data = 8'hA1;
    tick; chk("lat_c1", ov3, 0);
    in_data = 8'hA2;
    tick; chk("lat_c2", ov3, 0);
    in_data = 8'hA3;
    tick; chk("lat_c3_ov", ov3, 1); chk("lat_c3_od", od3, 8'hA1); chk("lat_peak_occ", oc3, 3);
    in_valid = 0;
    tick; chk("stream_a2", od3, 8'hA2);
    tick; chk("stream_a3", od3, 8'hA3);
    tick; chk("stream_empty", ov3, 0); chk("stream_occ0", oc3, 0);
    // fill under backpressure, then release
    out_ready = 0; in_valid = 1; in_data = 8'hB1;
    tick; in_data = 8'hB2;
    tick; in_data = 8'hB3;
    tick; in_data = 8'hB4;
    #1; chk("full_occ", oc3, 3); chk("full_ir", r3, 0);
    out_ready = 1;
    #1; chk("full_release_ir", r3, 1);
    tick; in_valid = 0;
    repeat (4) tick;
    chk("drain_occ", oc3, 0); chk("drain_ov", ov3, 0);
    // bubble collapse
    out_ready = 0; in_valid = 1; in_data = 8'h11;
    tick; in_valid = 0;
    tick; in_valid = 1; in_data = 8'h22;
    tick; in_valid = 0;
    tick; chk("bub_occ", oc3, 2); chk("bub_ov", ov3, 1); chk("bub_od", od3, 8'h11);
    out_ready = 1;
    tick; chk("bub_next_ov", ov3, 1); chk("bub_next_od", od3, 8'h22);
    tick; chk("bub_empty_ov", ov3, 0); chk("bub_empty_od", od3, RD);
    // flush during stall is deferred
    out_ready = 0; in_valid = 1; in_data = 8'hC1;
    tick; in_data = 8'hC2;
    tick; in_valid = 0;
    tick; chk("pre_stall_od", od3, 8'hC1); chk("pre_stall_occ", oc3, 2);
    stall = 1; flush = 1; out_ready = 1; in_valid = 1; in_data = 8'hC9;
    #1; chk("stall_ir", r3, 0);
    tick; flush = 0;
    repeat (3) tick;
    chk("stall_fp", fp3, 1); chk("stall_occ", oc3, 2); chk("stall_ov", ov3, 1); chk("stall_od", od3, 8'hC1);
    stall = 0;
    #1; chk("deferred_ir", r3, 0);
    tick; chk("defl_occ", oc3, 0); chk("defl_ov", ov3, 0); chk("defl_od", od3, RD); chk("defl_fp", fp3, 0);
    in_valid = 0;
    tick; chk("defl_dropped", ov3, 0);
    // flush with simultaneous push on DEPTH=2
    flush = 1; in_valid = 1; in_data = 8'h55; out_ready = 1;
    #1; chk("fl2_ir", r2, 0);
    tick; flush = 0; in_valid = 0;
    chk("fl2_occ", oc2, 0); chk("fl2_ov", ov2, 0);
    tick; chk("fl2_ov_next", ov2, 0); chk("fl2_occ_next", oc2, 0);
    // reset during stall with pending flush on DEPTH=4
    out_ready = 0; in_valid = 1; in_data = 8'hD1;
    tick; in_data = 8'hD2;
    tick; in_data = 8'hD3;
    tick; in_valid = 0;
    chk("d4_occ3", oc4, 3);
    stall = 1; flush = 1;
    tick; chk("d4_fp_set", fp4, 1);
    flush = 0; rst = 1;
    tick; rst = 0; stall = 0;
    #1;
    chk("d4_rst_occ", oc4, 0); chk("d4_rst_ov", ov4, 0); chk("d4_rst_od", od4, RD); chk("d4_rst_fp", fp4, 0);
    out_ready = 1; in_valid = 1; in_data = 8'hE5;
    tick; in_valid = 0; chk("d4_lat1", ov4, 0);
    tick; chk("d4_lat2", ov4, 0);
    tick; chk("d4_lat3", ov4, 0);
    tick; chk("d4_lat4_ov", ov4, 1); chk("d4_lat4_od", od4, 8'hE5);
    repeat (2) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
